dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Multi-cycle data-memory target answering the CPU MEM stage's load/store
//   requests over a valid/ready request channel and a one-cycle response pulse.
//   Replaces the single-cycle data memory when wait states are needed, so the
//   pipeline can be stalled against a realistic memory.
//   Word-addressed storage of NMEM 32-bit words; illegal addresses are flagged.
// PARAMETERS
//   NMEM  20  number of 32-bit words stored (word index 0..NMEM-1)
//   WAIT  2   wait cycles between acceptance and access (0..15)
// PORTS
//   clk         in   1   single clock, rising edge
//   reset       in   1   synchronous, active-high
//   req_valid   in   1   request present (memread or memwrite from MEM stage)
//   req_write   in   1   1 = store, 0 = load
//   req_addr    in   32  byte address (alurslt)
//   req_wdata   in   32  store data (data2)
//   req_ready   out  1   responder can accept a request this cycle
//   resp_valid  out  1   one-cycle pulse: access complete
//   resp_rdata  out  32  load data, valid while resp_valid=1
//   resp_err    out  1   misaligned or out-of-range address, valid with resp_valid
// BEHAVIOUR
//   Clock/reset: one clock, clk; reset is synchronous and active-high.
//   Reset:
//   - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0;
//     wait counter=0; all NMEM words cleared to 0.
//   - Reset mid-operation abandons the transaction: a pending store that has
//     not reached RESP is never written; no resp_valid follows.
//   FSM states IDLE, BUSY, RESP:
//   - IDLE: req_ready=1. An edge with req_valid=1 accepts the request and
//     latches write, addr and wdata.
//     - WAIT>0: go to BUSY with cnt=WAIT-1.
//     - WAIT=0: perform the access on the same edge and go to RESP.
//   - BUSY: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the
//     access and go to RESP.
//   - RESP: req_ready=0; resp_valid=1 for exactly one cycle, then IDLE.
//     There is no response backpressure.
//   Latency: a request accepted at edge N gives resp_valid=1 in the cycle
//   after edge N+WAIT. Back-to-back throughput is one request per WAIT+2
//   cycles.
//   Access, performed on the edge that enters RESP; idx = addr[31:2]:
//   - Error when addr[1:0]!=0 or idx>=NMEM (including upper address bits set).
//     Then resp_err=1, resp_rdata=0, and nothing is written.
//   - Load: resp_rdata=mem[idx], resp_err=0.
//   - Store: mem[idx]<=wdata, resp_err=0, resp_rdata=wdata (echo).
//   Hold rules:
//   - resp_rdata and resp_err are registered and hold their values until the
//     next access.
//   - req_valid while req_ready=0 is ignored, not queued. The requester must
//     hold req_valid and the request fields stable until it sees req_ready=1
//     at the sampling edge.
//   - A load immediately after a store to the same index returns the new data.
//   Arithmetic: idx compare is 30-bit unsigned. The WAIT counter is 4-bit and
//   never wraps (it only decrements from WAIT-1 to 0).
// TESTING
//   1 reset, then load addr 0x8 -> resp_valid 3 cycles after accept (WAIT=2),
//     rdata=0, err=0.
//   2 store 0xDEADBEEF @0x10, then load @0x10 -> rdata=0xDEADBEEF, err=0;
//     req_ready low 3 cycles per transaction.
//   3 load @0x6 (misaligned) and @4*NMEM=0x50 -> err=1, rdata=0; a store
//     @0x50 leaves all words unchanged.
//   4 req_valid held high continuously with alternating store/load -> exactly
//     one accept per 4 cycles, no lost or duplicated responses.
//   5 store 0x1234 @0x4, assert reset during BUSY -> no resp_valid; later load
//     @0x4 returns 0.
//   6 rebuild with WAIT=0: load @0x0 -> resp_valid in the cycle after accept;
//     back-to-back period is 2 cycles.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM-stage requester and the
// multi-cycle data-memory responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: accepts one load/store at a time, waits WAIT
// cycles, performs the access and answers with a one-cycle response pulse.
// Misaligned or out-of-range word addresses are reported instead of accessed.
module dmem_responder #(
   parameter int NMEM = 20,
   parameter int WAIT = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam int          IW     = (NMEM > 1) ? $clog2(NMEM) : 1;
   localparam logic [29:0] NMEM_W = 30'(NMEM);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        write_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;
   logic [31:0] mem_q [NMEM];

   logic        accWrite_d;
   logic [31:0] accAddr_d;
   logic [31:0] accWdata_d;
   logic [29:0] accIdx_d;
   logic        accErr_d;
   logic [31:0] accRdata_d;
   logic        doAccess_d;

   // With no wait states the access happens on the accepting edge, so it
   // must use the live request; otherwise it uses the latched copy.
   always_comb begin
      accWrite_d = write_q;
      accAddr_d  = addr_q;
      accWdata_d = wdata_q;
      if (WAIT == 0) begin
         accWrite_d = bus.req_write;
         accAddr_d  = bus.req_addr;
         accWdata_d = bus.req_wdata;
      end
      accIdx_d   = accAddr_d[31:2];
      accErr_d   = (accAddr_d[1:0] != 2'b00) || (accIdx_d >= NMEM_W);
      accRdata_d = '0;
      if (!accErr_d) begin
         accRdata_d = accWrite_d ? accWdata_d : mem_q[accIdx_d[IW-1:0]];
      end
      doAccess_d = ((state_q == IDLE) && bus.req_valid && (WAIT == 0)) ||
                   ((state_q == BUSY) && (cnt_q == 4'd0));
   end

   // Handshake FSM, wait counter, registered response and the storage array.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         for (int i = 0; i < NMEM; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  write_q     <= bus.req_write;
                  addr_q      <= bus.req_addr;
                  wdata_q     <= bus.req_wdata;
                  req_ready_q <= 1'b0;
                  if (WAIT == 0) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= 4'(WAIT - 1);
                  end
               end
            end
            BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
               end
            end
            RESP: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase

         if (doAccess_d) begin
            resp_rdata_q <= accRdata_d;
            resp_err_q   <= accErr_d;
            if (accWrite_d && !accErr_d) begin
               mem_q[accIdx_d[IW-1:0]] <= accWdata_d;
            end
         end
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT=2 and one with
// WAIT=0 share the request stimulus; 'sel' picks whose outputs are observed.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic        reqValid;
   logic        reqWrite;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;

   logic        obsReady;
   logic        obsValid;
   logic [31:0] obsRdata;
   logic        obsErr;

   int vectors = 0;
   int misses  = 0;

   logic        gotResp;
   logic [31:0] respRd;
   logic        respErr;
   int          latency;
   int          lowCount;
   logic        readyAfter;
   logic        validAfter;
   logic [31:0] rdAfter;

   dmem_responder_if busA ();
   dmem_responder_if busB ();

   assign busA.req_valid = reqValid;
   assign busA.req_write = reqWrite;
   assign busA.req_addr  = reqAddr;
   assign busA.req_wdata = reqWdata;
   assign busB.req_valid = reqValid;
   assign busB.req_write = reqWrite;
   assign busB.req_addr  = reqAddr;
   assign busB.req_wdata = reqWdata;

   assign obsReady = sel ? busB.req_ready  : busA.req_ready;
   assign obsValid = sel ? busB.resp_valid : busA.resp_valid;
   assign obsRdata = sel ? busB.resp_rdata : busA.resp_rdata;
   assign obsErr   = sel ? busB.resp_err   : busA.resp_err;

   dmem_responder #(.NMEM(20), .WAIT(2)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   dmem_responder #(.NMEM(20), .WAIT(0)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Hard stop in case anything stalls far beyond the expected run length.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it when it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         misses++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Hold reset over two rising edges.
   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Issue one request, wait for acceptance and for its response (bounded).
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      reqValid = 1'b1;
      reqWrite = w;
      reqAddr  = a;
      reqWdata = d;
      for (int g = 0; g < 20 && !obsReady; g++) @(negedge clk);
      @(posedge clk);
      #1 reqValid = 1'b0;
      gotResp  = 1'b0;
      respRd   = '0;
      respErr  = 1'b0;
      latency  = 0;
      lowCount = 0;
      for (int c = 1; c <= 20 && !gotResp; c++) begin
         @(negedge clk);
         if (!obsReady) lowCount++;
         if (obsValid) begin
            gotResp = 1'b1;
            latency = c;
            respRd  = obsRdata;
            respErr = obsErr;
         end
      end
      @(negedge clk);
      readyAfter = obsReady;
      validAfter = obsValid;
      rdAfter    = obsRdata;
   endtask

   // One full transaction with all of its expected response properties.
   task automatic transact(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] expRd,
                           input logic expErr, input int expLat);
      applyStimulus(w, a, d);
      checkOutput({tag, " got"},     32'(gotResp),    32'd1);
      checkOutput({tag, " rdata"},   respRd,          expRd);
      checkOutput({tag, " err"},     32'(respErr),    32'(expErr));
      checkOutput({tag, " latency"}, 32'(latency),    32'(expLat));
      checkOutput({tag, " lowrdy"},  32'(lowCount),   32'(expLat));
      checkOutput({tag, " rdyback"}, 32'(readyAfter), 32'd1);
      checkOutput({tag, " pulse"},   32'(validAfter), 32'd0);
      checkOutput({tag, " hold"},    rdAfter,         expRd);
   endtask

   // Keep req_valid high across alternating store/load requests and check
   // acceptance spacing, latency and in-order, non-duplicated responses.
   task automatic streamTest(input int period, input int expLat);
      logic [31:0] sAddr [4];
      logic [31:0] sData [4];
      logic        sWr   [4];
      logic [31:0] sExp  [4];
      int          acc [$];
      int          k, nResp, cyc, lastAcc, dup, a;
      logic        advance;
      sAddr = '{32'h14, 32'h14, 32'h18, 32'h18};
      sData = '{32'hA5A5_0000, 32'h0, 32'h5A5A_1111, 32'h0};
      sWr   = '{1'b1, 1'b0, 1'b1, 1'b0};
      sExp  = '{32'hA5A5_0000, 32'hA5A5_0000, 32'h5A5A_1111, 32'h5A5A_1111};
      k = 0; nResp = 0; cyc = 0; lastAcc = -1; dup = 0; advance = 1'b0;
      @(negedge clk);
      reqValid = 1'b1;
      reqWrite = sWr[0];
      reqAddr  = sAddr[0];
      reqWdata = sData[0];
      while (cyc < 60 && nResp < 4) begin
         if (obsValid) begin
            if (acc.size() > 0) begin
               a = acc.pop_front();
               checkOutput("stream latency", 32'(cyc - a), 32'(expLat));
               checkOutput("stream rdata",   obsRdata,     sExp[nResp]);
               checkOutput("stream err",     32'(obsErr),  32'd0);
            end else begin
               checkOutput("stream spurious", 32'd1, 32'd0);
            end
            nResp++;
         end
         if (advance) begin
            advance = 1'b0;
            k++;
            if (k < 4) begin
               reqWrite = sWr[k];
               reqAddr  = sAddr[k];
               reqWdata = sData[k];
            end else begin
               reqValid = 1'b0;
            end
         end
         if (reqValid && obsReady) begin
            if (lastAcc >= 0) checkOutput("stream period", 32'(cyc - lastAcc), 32'(period));
            lastAcc = cyc;
            acc.push_back(cyc);
            advance = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      reqValid = 1'b0;
      checkOutput("stream count", 32'(nResp), 32'd4);
      repeat (8) begin
         @(negedge clk);
         if (obsValid) dup++;
      end
      checkOutput("stream dup", 32'(dup), 32'd0);
   endtask

   // Directed test sequence.
   initial begin
      logic seen;
      reset    = 1'b1;
      sel      = 1'b0;
      reqValid = 1'b0;
      reqWrite = 1'b0;
      reqAddr  = '0;
      reqWdata = '0;
      doReset();
      @(negedge clk);
      checkOutput("reset ready", 32'(obsReady), 32'd1);
      checkOutput("reset valid", 32'(obsValid), 32'd0);
      checkOutput("reset rdata", obsRdata,      32'd0);
      checkOutput("reset err",   32'(obsErr),   32'd0);

      transact("load 0x8",   1'b0, 32'h8,  32'h0,         32'h0,         1'b0, 3);
      transact("store 0x10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3);
      transact("load 0x10",  1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 3);

      transact("load 0x6",   1'b0, 32'h6,         32'h0,         32'h0, 1'b1, 3);
      transact("load 0x50",  1'b0, 32'h50,        32'h0,         32'h0, 1'b1, 3);
      transact("load upper", 1'b0, 32'h8000_0010, 32'h0,         32'h0, 1'b1, 3);
      transact("store 0x50", 1'b1, 32'h50,        32'hCAFE_F00D, 32'h0, 1'b1, 3);
      transact("load 0x4C",  1'b0, 32'h4C,        32'h0,         32'h0, 1'b0, 3);
      transact("reload 0x10", 1'b0, 32'h10,       32'h0, 32'hDEAD_BEEF, 1'b0, 3);

      streamTest(4, 3);

      // Store accepted, then reset lands while it is still waiting.
      @(negedge clk);
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 32'h4;
      reqWdata = 32'h0000_1234;
      for (int g = 0; g < 20 && !obsReady; g++) @(negedge clk);
      @(posedge clk);
      #1 reqValid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (obsValid) seen = 1'b1;
      end
      checkOutput("abort no resp", 32'(seen),     32'd0);
      checkOutput("abort ready",   32'(obsReady), 32'd1);
      transact("load 0x4 after abort", 1'b0, 32'h4,  32'h0, 32'h0, 1'b0, 3);
      transact("load 0x10 cleared",    1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 3);

      sel = 1'b1;
      doReset();
      transact("w0 load 0x0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
      streamTest(2, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
